// File: rtl/cargador_instrucciones.sv
// rtl/cargador_instrucciones.sv - loads 32-bit instruction words into byte-wide instruction memory, big-endian
module cargador_instrucciones #(
  parameter int MEM_BYTES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inicio,
  input  logic [31:0] dir_base,
  input  logic [15:0] num_palabras,
  input  logic [31:0] palabra,
  input  logic        palabra_valida,
  output logic        palabra_lista,
  output logic        mem_we,
  output logic [31:0] mem_dir,
  output logic [7:0]  mem_dato,
  output logic        ocupado,
  output logic        terminado,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, ESPERA, ESCRIBE, FIN} estado_t;

  estado_t     estado;
  logic [31:0] dir_act;
  logic [31:0] buffer;
  logic [15:0] restantes;
  logic [1:0]  indice;

  logic [33:0] dir_fin;
  logic        rechazo;
  logic        handshake;

  // 34-bit end address so a base near 2^32 cannot wrap past the size check
  assign dir_fin   = {2'b00, dir_base} + {16'd0, num_palabras, 2'b00};
  assign rechazo   = (dir_base[1:0] != 2'b00) || (dir_fin > 34'(MEM_BYTES));

  // Ready in ESPERA, and on the last byte when another word is still due
  assign palabra_lista = (estado == ESPERA) ||
                         ((estado == ESCRIBE) && (indice == 2'd3) && (restantes > 16'd1));
  assign handshake     = palabra_valida && palabra_lista;

  assign ocupado   = (estado == ESPERA) || (estado == ESCRIBE);
  assign terminado = (estado == FIN);
  assign mem_we    = (estado == ESCRIBE);
  assign mem_dir   = mem_we ? (dir_act + {30'd0, indice}) : 32'd0;

  // Byte 0 of the word is the most significant one, matching the fetch-side reassembly
  always_comb begin
    mem_dato = 8'd0;
    if (mem_we) begin
      case (indice)
        2'd0:    mem_dato = buffer[31:24];
        2'd1:    mem_dato = buffer[23:16];
        2'd2:    mem_dato = buffer[15:8];
        default: mem_dato = buffer[7:0];
      endcase
    end
  end

  // Load sequencer: request check, word capture, four byte writes per word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= IDLE;
      dir_act   <= 32'd0;
      buffer    <= 32'd0;
      restantes <= 16'd0;
      indice    <= 2'd0;
      error     <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (inicio) begin
            error <= rechazo;
            if (rechazo || (num_palabras == 16'd0)) begin
              estado <= FIN;
            end else begin
              dir_act   <= dir_base;
              restantes <= num_palabras;
              estado    <= ESPERA;
            end
          end
        end
        ESPERA: begin
          if (handshake) begin
            buffer <= palabra;
            indice <= 2'd0;
            estado <= ESCRIBE;
          end
        end
        ESCRIBE: begin
          if (indice != 2'd3) begin
            indice <= indice + 2'd1;
          end else begin
            dir_act   <= dir_act + 32'd4;
            restantes <= restantes - 16'd1;
            if (handshake) begin
              buffer <= palabra;
              indice <= 2'd0;
            end else if (restantes == 16'd1) begin
              estado <= FIN;
            end else begin
              estado <= ESPERA;
            end
          end
        end
        FIN: begin
          estado <= IDLE;
        end
        default: begin
          estado <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cargador_instrucciones.sv
// tb/tb_cargador_instrucciones.sv - randomized self-checking bench for cargador_instrucciones
module tb_cargador_instrucciones;

  localparam int MEM_BYTES = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inicio = 1'b0;
  logic [31:0] dir_base = 32'd0;
  logic [15:0] num_palabras = 16'd0;
  logic [31:0] palabra = 32'd0;
  logic        palabra_valida = 1'b0;
  logic        palabra_lista;
  logic        mem_we;
  logic [31:0] mem_dir;
  logic [7:0]  mem_dato;
  logic        ocupado;
  logic        terminado;
  logic        error;

  cargador_instrucciones #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .dir_base(dir_base),
    .num_palabras(num_palabras), .palabra(palabra), .palabra_valida(palabra_valida),
    .palabra_lista(palabra_lista), .mem_we(mem_we), .mem_dir(mem_dir),
    .mem_dato(mem_dato), .ocupado(ocupado), .terminado(terminado), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed memory image and write log, collected away from the active edge
  logic [7:0]  mem_img [0:MEM_BYTES-1];
  int          wr_cyc_q[$];
  logic [31:0] wr_dir_q[$];
  logic [7:0]  wr_dat_q[$];
  int          term_cnt = 0;
  int          term_cyc = -1;
  int          idle_junk = 0;
  logic [31:0] words_q[$];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cyc_q.push_back(cyc);
      wr_dir_q.push_back(mem_dir);
      wr_dat_q.push_back(mem_dato);
      if (mem_dir < MEM_BYTES) mem_img[mem_dir] = mem_dato;
    end else if (mem_dir != 32'd0 || mem_dato != 8'd0) begin
      idle_junk++;
    end
    if (terminado) begin
      if (term_cnt == 0) term_cyc = cyc;
      term_cnt++;
    end
  end

  task automatic run_load(input string name, input logic [31:0] base, input int n,
                          input int stall, input bit mid_start);
    longint      fin;
    bit          accept;
    bit          loads;
    bit          hs;
    int          t, waited, bad, busy_drop, exp_cnt;
    int          hs_cyc[$];
    logic [31:0] w;
    logic [31:0] exp_dir;
    logic [7:0]  exp_dat;

    fin     = longint'(base) + 4 * longint'(n);
    accept  = (base[1:0] == 2'b00) && (fin <= MEM_BYTES);
    loads   = accept && (n > 0);
    exp_cnt = loads ? 4 * n : 0;
    if (loads) while (words_q.size() < n) words_q.push_back($urandom);
    wr_cyc_q.delete(); wr_dir_q.delete(); wr_dat_q.delete();
    term_cnt = 0; term_cyc = -1; busy_drop = 0;

    @(posedge clk); #1;
    inicio = 1'b1; dir_base = base; num_palabras = 16'(n);
    @(negedge clk); t = cyc;
    @(posedge clk); #1;
    inicio = 1'b0; dir_base = $urandom; num_palabras = 16'($urandom);
    @(negedge clk);
    check({name, " ocupado t+1"}, 64'(ocupado), 64'(loads));
    check({name, " lista t+1"}, 64'(palabra_lista), 64'(loads));
    check({name, " terminado t+1"}, 64'(terminado), 64'(!loads));
    check({name, " error t+1"}, 64'(error), 64'(!accept));
    @(posedge clk); #1;

    if (loads) begin
      for (int i = 0; i < n; i++) begin
        if (i > 0 && stall > 0) begin
          palabra_valida = 1'b0;
          for (int s = 0; s < stall; s++) begin
            inicio = mid_start && (s == 0);
            if (mid_start) begin dir_base = 32'd0; num_palabras = 16'd7; end
            @(negedge clk);
            if (!ocupado) busy_drop++;
            @(posedge clk); #1;
          end
          inicio = 1'b0;
        end
        palabra = words_q[i];
        palabra_valida = 1'b1;
        waited = 0;
        hs = 1'b0;
        while (!hs && waited < 50) begin
          @(negedge clk);
          hs = palabra_lista;
          if (hs) hs_cyc.push_back(cyc);
          else begin @(posedge clk); #1; waited++; end
        end
        if (!hs) begin
          check({name, " handshake timeout"}, 64'(hs), 64'd1);
          break;
        end
        @(posedge clk); #1;
      end
      palabra_valida = 1'b0;
      waited = 0;
      while (term_cnt == 0 && waited < 40) begin @(negedge clk); #1; waited++; end
      check({name, " terminado seen"}, 64'(term_cnt > 0), 64'd1);
      if (wr_cyc_q.size() > 0)
        check({name, " terminado after last byte"}, 64'(term_cyc), 64'(wr_cyc_q[$] + 1));
      if (stall > 0) check({name, " ocupado during stall"}, 64'(busy_drop), 64'd0);
    end else begin
      check({name, " terminado cycle"}, 64'(term_cyc), 64'(t + 1));
    end

    repeat (3) @(negedge clk);
    #1;
    check({name, " single terminado"}, 64'(term_cnt), 64'd1);
    check({name, " idle after"}, 64'(ocupado), 64'd0);
    check({name, " error held"}, 64'(error), 64'(!accept));
    check({name, " write count"}, 64'(wr_dir_q.size()), 64'(exp_cnt));

    bad = 0;
    if (wr_dir_q.size() == exp_cnt && hs_cyc.size() == n) begin
      for (int i = 0; i < exp_cnt; i++) begin
        w = words_q[i / 4];
        exp_dir = base + 32'(i);
        exp_dat = 8'(w >> (8 * (3 - (i % 4))));
        if (wr_dir_q[i] !== exp_dir || wr_dat_q[i] !== exp_dat) bad++;
        if (wr_cyc_q[i] != hs_cyc[i / 4] + 1 + (i % 4)) bad++;
      end
    end
    if (loads) check({name, " bytes and timing"}, 64'(bad), 64'd0);
    if (loads && stall == 0 && wr_cyc_q.size() == exp_cnt)
      check({name, " contiguous"}, 64'(wr_cyc_q[$] - wr_cyc_q[0]), 64'(exp_cnt - 1));
    words_q.delete();
  endtask

  initial begin
    int  waited;
    bit  hit;
    logic [31:0] b;

    #1;
    check("reset mem_we", 64'(mem_we), 64'd0);
    check("reset mem_dir", 64'(mem_dir), 64'd0);
    check("reset mem_dato", 64'(mem_dato), 64'd0);
    check("reset ocupado", 64'(ocupado), 64'd0);
    check("reset terminado", 64'(terminado), 64'd0);
    check("reset error", 64'(error), 64'd0);
    check("reset lista", 64'(palabra_lista), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    words_q = '{32'h8C220004};
    run_load("single", 32'd0, 1, 0, 1'b0);
    check("single bytes", 64'({mem_img[0], mem_img[1], mem_img[2], mem_img[3]}), 64'h8C220004);

    words_q = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    run_load("b2b", 32'd8, 3, 0, 1'b0);
    check("b2b fetch 12", 64'({mem_img[12], mem_img[13], mem_img[14], mem_img[15]}), 64'h55667788);

    words_q = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    run_load("stall", 32'd8, 3, 5, 1'b1);

    run_load("rej unaligned", 32'd2, 1, 0, 1'b0);
    run_load("rej overflow", 32'd996, 2, 0, 1'b0);
    run_load("edge 996", 32'd996, 1, 0, 1'b0);
    run_load("rej wrap", 32'hFFFF_FFFC, 1, 0, 1'b0);
    run_load("rej big n", 32'd0, 65535, 0, 1'b0);
    run_load("zero count", 32'd0, 0, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      b = 32'($urandom_range(0, 255)) * 32'd4;
      if ($urandom_range(0, 3) == 0) b = b + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) b = 32'd1000 - 32'd4 * 32'($urandom_range(0, 4));
      run_load($sformatf("rnd%0d", i), b, int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    wr_cyc_q.delete(); wr_dir_q.delete(); wr_dat_q.delete();
    term_cnt = 0;
    @(posedge clk); #1;
    inicio = 1'b1; dir_base = 32'd0; num_palabras = 16'd3;
    @(posedge clk); #1;
    inicio = 1'b0; palabra = $urandom; palabra_valida = 1'b1;
    waited = 0; hit = 1'b0;
    while (!hit && waited < 60) begin
      @(negedge clk);
      if (mem_we && mem_dir == 32'd6) hit = 1'b1;
      else waited++;
    end
    check("rst reached word2 k2", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst mem_we", 64'(mem_we), 64'd0);
    check("rst mem_dir", 64'(mem_dir), 64'd0);
    check("rst mem_dato", 64'(mem_dato), 64'd0);
    check("rst ocupado", 64'(ocupado), 64'd0);
    check("rst lista", 64'(palabra_lista), 64'd0);
    check("rst terminado", 64'(terminado), 64'd0);
    palabra_valida = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst no terminado", 64'(term_cnt), 64'd0);

    run_load("post reset", 32'd0, 1, 0, 1'b0);

    check("idle mem_dir/dato zero", 64'(idle_junk), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
